// File: rtl/ev22_inst_prefetch_if.sv
// Prefetch-queue bus bundle: program-memory read port, redirect request and decode-side handshake.
// master = prefetch queue, slave = memory/decode environment.
interface ev22_inst_prefetch_if #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 12,
  parameter int unsigned IW    = 20
);
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic          PM_RD;
  logic [AW-1:0] PM_ADDR;
  logic [IW-1:0] PM_DATA;
  logic          FLUSH;
  logic [AW-1:0] FLUSH_ADDR;
  logic [IW-1:0] INST;
  logic [AW-1:0] INST_PC;
  logic          INST_VALID;
  logic          INST_ACCEPT;
  logic [LW-1:0] LEVEL;

  modport master (
    output PM_RD, PM_ADDR, INST, INST_PC, INST_VALID, LEVEL,
    input  PM_DATA, FLUSH, FLUSH_ADDR, INST_ACCEPT
  );

  modport slave (
    input  PM_RD, PM_ADDR, INST, INST_PC, INST_VALID, LEVEL,
    output PM_DATA, FLUSH, FLUSH_ADDR, INST_ACCEPT
  );
endinterface

// File: rtl/ev22_inst_prefetch.sv
// Instruction prefetch queue feeding the MIR decoders: credit-limited fetch, FIFO, flush redirect.
// Optional macro PREFETCH_BYPASS_EN presents a return arriving into an empty queue in the same cycle.
module ev22_inst_prefetch #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 12,
  parameter int unsigned IW    = 20
) (
  input logic                  CLK,
  input logic                  nRST,
  ev22_inst_prefetch_if.master bus
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LW = $clog2(DEPTH) + 1;
  localparam int unsigned CW = LW + 1;

  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          rd_q, rd_d;
  logic          ret_q, ret_d;
  logic [AW-1:0] ret_pc_q;
  logic [PW-1:0] wp_q, wp_d;
  logic [PW-1:0] rp_q, rp_d;
  logic [LW-1:0] level_q, level_d;

  logic [IW-1:0] data_mem_q [DEPTH];
  logic [AW-1:0] pc_mem_q   [DEPTH];

  logic push_c, pop_c, write_c, byp_c;

  // Queue bookkeeping and fetch issue; flush overrides everything and restarts fetch at FLUSH_ADDR.
  always_comb begin
    push_c  = ret_q && !bus.FLUSH;
    pop_c   = bus.INST_ACCEPT && (level_q != '0) && !bus.FLUSH;
    byp_c   = 1'b0;
`ifdef PREFETCH_BYPASS_EN
    byp_c   = push_c && (level_q == '0);
`endif
    write_c = push_c && !(byp_c && bus.INST_ACCEPT);
    level_d = level_q + LW'(write_c) - LW'(pop_c);
    wp_d    = wp_q + PW'(write_c);
    rp_d    = rp_q + PW'(pop_c);
    ret_d   = rd_q && !bus.FLUSH;
    rd_d    = 1'b0;
    addr_d  = addr_q;
    pc_d    = pc_q;

    if (bus.FLUSH) begin
      level_d = '0;
      wp_d    = '0;
      rp_d    = '0;
      rd_d    = 1'b1;
      addr_d  = bus.FLUSH_ADDR;
      pc_d    = bus.FLUSH_ADDR + AW'(1);
    end else if ((CW'(level_d) + CW'(rd_q)) < CW'(DEPTH)) begin
      // The read issued this cycle still holds a slot until it lands.
      rd_d    = 1'b1;
      addr_d  = pc_q;
      pc_d    = pc_q + AW'(1);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pc_q     <= '0;
      addr_q   <= '0;
      rd_q     <= 1'b0;
      ret_q    <= 1'b0;
      ret_pc_q <= '0;
      wp_q     <= '0;
      rp_q     <= '0;
      level_q  <= '0;
    end else begin
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      rd_q     <= rd_d;
      ret_q    <= ret_d;
      ret_pc_q <= addr_q;
      wp_q     <= wp_d;
      rp_q     <= rp_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (write_c) begin
      data_mem_q[wp_q] <= bus.PM_DATA;
      pc_mem_q[wp_q]   <= ret_pc_q;
    end
  end

  // Head presentation; an empty queue shows a NOP at PC 0.
  always_comb begin
    bus.PM_RD      = rd_q;
    bus.PM_ADDR    = addr_q;
    bus.LEVEL      = level_q;
    bus.INST_VALID = 1'b0;
    bus.INST       = '0;
    bus.INST_PC    = '0;
    if (level_q != '0) begin
      bus.INST_VALID = 1'b1;
      bus.INST       = data_mem_q[rp_q];
      bus.INST_PC    = pc_mem_q[rp_q];
    end else if (byp_c) begin
      bus.INST_VALID = 1'b1;
      bus.INST       = bus.PM_DATA;
      bus.INST_PC    = ret_pc_q;
    end
  end
endmodule

// File: tb/tb_ev22_inst_prefetch.sv
// Bench for ev22_inst_prefetch: queue-level reference model checked every cycle plus directed literals.
module tb_ev22_inst_prefetch;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ev22_inst_prefetch_if bus ();

  ev22_inst_prefetch dut (
    .CLK  (clk),
    .nRST (rst_n),
    .bus  (bus.master)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Program memory: word at address k is 20'h10000+k, one cycle after the read strobe.
  initial begin
    bus.PM_DATA = '0;
    forever begin
      @(posedge clk);
      bus.PM_DATA <= bus.PM_RD ? (20'h10000 + 20'(bus.PM_ADDR)) : 20'hBAD00;
    end
  end

  // Reference model: queue of PCs, one outstanding read, fetch PC.
  int mq[$];
  bit m_rd     = 0;
  int m_addr   = 0;
  bit m_ret    = 0;
  int m_ret_pc = 0;
  int m_pc     = 0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete();
        m_rd = 0; m_addr = 0; m_ret = 0; m_ret_pc = 0; m_pc = 0;
      end else if (bus.FLUSH) begin
        mq.delete();
        m_ret  = 0;
        m_rd   = 1;
        m_addr = int'(bus.FLUSH_ADDR);
        m_pc   = (m_addr + 1) % 4096;
      end else begin
        if (bus.INST_ACCEPT && mq.size() > 0) void'(mq.pop_front());
        if (m_ret) mq.push_back(m_ret_pc);
        m_ret    = m_rd;
        m_ret_pc = m_addr;
        if (mq.size() + (m_ret ? 1 : 0) < DEPTH) begin
          m_rd   = 1;
          m_addr = m_pc;
          m_pc   = (m_pc + 1) % 4096;
        end else begin
          m_rd = 0;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("pm_rd",   32'(bus.PM_RD),      32'(m_rd));
      chk("pm_addr", 32'(bus.PM_ADDR),    32'(m_addr));
      chk("level",   32'(bus.LEVEL),      32'(mq.size()));
      chk("valid",   32'(bus.INST_VALID), 32'(mq.size() > 0));
      chk("inst",    32'(bus.INST),       (mq.size() > 0) ? 32'(20'h10000 + 20'(mq[0])) : 32'd0);
      chk("inst_pc", 32'(bus.INST_PC),    (mq.size() > 0) ? 32'(mq[0]) : 32'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit got;
    rst_n = 1'b0;
    bus.FLUSH = 1'b0;
    bus.FLUSH_ADDR = '0;
    bus.INST_ACCEPT = 1'b0;
    cyc(); cyc();
    chk("rst_pm_rd", 32'(bus.PM_RD), 32'd0);
    chk("rst_level", 32'(bus.LEVEL), 32'd0);
    chk("rst_valid", 32'(bus.INST_VALID), 32'd0);

    // Streaming from reset
    bus.INST_ACCEPT = 1'b1;
    rst_n = 1'b1;
    cyc();
    chk("t1_rd0",   32'(bus.PM_RD), 32'd1);
    chk("t1_addr0", 32'(bus.PM_ADDR), 32'h0);
    cyc();
    chk("t1_addr1", 32'(bus.PM_ADDR), 32'h1);
    chk("t1_val0",  32'(bus.INST_VALID), 32'd0);
    cyc();
    chk("t1_inst0", 32'(bus.INST), 32'h10000);
    chk("t1_pc0",   32'(bus.INST_PC), 32'h0);
    cyc();
    chk("t1_inst1", 32'(bus.INST), 32'h10001);
    chk("t1_lvl1",  32'(bus.LEVEL), 32'd1);
    cyc();
    chk("t1_pc2",   32'(bus.INST_PC), 32'h2);

    // Stall: fill to DEPTH, then single accepts
    bus.INST_ACCEPT = 1'b0;
    repeat (10) cyc();
    chk("t2_full",  32'(bus.LEVEL), 32'd4);
    chk("t2_rd0",   32'(bus.PM_RD), 32'd0);
    chk("t2_head",  32'(bus.INST_PC), 32'h2);
    bus.INST_ACCEPT = 1'b1;
    cyc();
    chk("t2_rd1",   32'(bus.PM_RD), 32'd1);
    chk("t2_addr6", 32'(bus.PM_ADDR), 32'h6);
    chk("t2_lvl3",  32'(bus.LEVEL), 32'd3);
    chk("t2_pc3",   32'(bus.INST_PC), 32'h3);
    bus.INST_ACCEPT = 1'b0;
    cyc();
    chk("t2_rdoff", 32'(bus.PM_RD), 32'd0);
    cyc();
    chk("t2_refill", 32'(bus.LEVEL), 32'd4);
    chk("t2_rdoff2", 32'(bus.PM_RD), 32'd0);
    bus.INST_ACCEPT = 1'b1;
    cyc();
    chk("t3_pre_lvl", 32'(bus.LEVEL), 32'd3);
    chk("t3_pre_rd",  32'(bus.PM_RD), 32'd1);

    // Flush with a read in flight
    bus.FLUSH = 1'b1; bus.FLUSH_ADDR = 12'h3F0; bus.INST_ACCEPT = 1'b0;
    cyc();
    chk("t3_val",  32'(bus.INST_VALID), 32'd0);
    chk("t3_lvl",  32'(bus.LEVEL), 32'd0);
    chk("t3_addr", 32'(bus.PM_ADDR), 32'h3F0);
    chk("t3_inst", 32'(bus.INST), 32'h0);
    bus.FLUSH = 1'b0; bus.INST_ACCEPT = 1'b1;
    cyc();
    chk("t3_stale", 32'(bus.INST_VALID), 32'd0);
    cyc();
    chk("t3_pc",   32'(bus.INST_PC), 32'h3F0);
    chk("t3_data", 32'(bus.INST), 32'h103F0);

    // PC wrap
    bus.FLUSH = 1'b1; bus.FLUSH_ADDR = 12'hFFE;
    cyc();
    chk("t4_addr", 32'(bus.PM_ADDR), 32'hFFE);
    bus.FLUSH = 1'b0;
    cyc(); cyc();
    chk("t4_pc0",   32'(bus.INST_PC), 32'hFFE);
    chk("t4_awrap", 32'(bus.PM_ADDR), 32'h000);
    cyc();
    chk("t4_pc1", 32'(bus.INST_PC), 32'hFFF);
    cyc();
    chk("t4_pc2", 32'(bus.INST_PC), 32'h000);
    chk("t4_d2",  32'(bus.INST), 32'h10000);
    cyc();
    chk("t4_pc3", 32'(bus.INST_PC), 32'h001);

    // Flush overriding accept, then back-to-back flushes
    bus.INST_ACCEPT = 1'b0;
    cyc();
    chk("t5_lvl2", 32'(bus.LEVEL), 32'd2);
    bus.FLUSH = 1'b1; bus.FLUSH_ADDR = 12'h100; bus.INST_ACCEPT = 1'b1;
    cyc();
    chk("t5_lvl0", 32'(bus.LEVEL), 32'd0);
    chk("t5_a100", 32'(bus.PM_ADDR), 32'h100);
    bus.FLUSH_ADDR = 12'h200;
    cyc();
    chk("t5_a200", 32'(bus.PM_ADDR), 32'h200);
    bus.FLUSH = 1'b0;
    cyc();
    chk("t5_val0", 32'(bus.INST_VALID), 32'd0);
    cyc();
    chk("t5_pc200", 32'(bus.INST_PC), 32'h200);

    // Async reset mid-stream
    bus.INST_ACCEPT = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      cyc();
      if (bus.LEVEL == 3'd3) got = 1'b1;
    end
    chk("t6_lvl3", 32'(bus.LEVEL), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rd",    32'(bus.PM_RD), 32'd0);
    chk("t6_addr",  32'(bus.PM_ADDR), 32'd0);
    chk("t6_inst",  32'(bus.INST), 32'd0);
    chk("t6_pc",    32'(bus.INST_PC), 32'd0);
    chk("t6_valid", 32'(bus.INST_VALID), 32'd0);
    chk("t6_level", 32'(bus.LEVEL), 32'd0);
    cyc(); cyc();
    rst_n = 1'b1;
    bus.INST_ACCEPT = 1'b1;
    cyc();
    chk("t6_restart", 32'(bus.PM_ADDR), 32'h0);
    chk("t6_rd1",     32'(bus.PM_RD), 32'd1);
    cyc(); cyc();
    chk("t6_inst0", 32'(bus.INST), 32'h10000);

    repeat (2) cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
